// File: rtl/store_result_monitor.sv
// store_result_monitor
// Watches the data-memory write port of the core and decides the run outcome:
// pass on the signature store, fail on an illegal store, wrong signature data
// or a timeout. Counts cycles until the decision and keeps a show-ahead FIFO
// log of every store seen while the run is still in progress.

module store_result_monitor #(
  parameter logic [31:0] PASS_ADDR      = 32'd100,
  parameter logic [31:0] PASS_DATA      = 32'd25,
  parameter logic [31:0] SCRATCH_ADDR   = 32'd96,
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd10000,
  parameter int          LOG_DEPTH      = 8
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        MemWrite,
  input  logic [31:0] ALUResult,
  input  logic [31:0] WriteData,
  output logic        done,
  output logic        pass,
  output logic [1:0]  fail_code,
  output logic [31:0] cycle_count,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [31:0] log_addr,
  output logic [31:0] log_data,
  output logic        log_overflow
);

  localparam int PW = $clog2(LOG_DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] DEPTH_CNT = CW'(LOG_DEPTH);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_ILLEGAL = 2'b01;
  localparam logic [1:0] CODE_DATA    = 2'b10;
  localparam logic [1:0] CODE_TIMEOUT = 2'b11;

  typedef enum logic [1:0] {
    ST_RUN  = 2'b00,
    ST_PASS = 2'b01,
    ST_FAIL = 2'b10
  } state_t;

  state_t      state;
  state_t      next_state;
  logic [1:0]  next_code;
  logic [31:0] count_inc;

  // FIFO storage and bookkeeping
  logic [31:0]   addr_mem [LOG_DEPTH];
  logic [31:0]   data_mem [LOG_DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [CW-1:0] log_count;
  logic          store_hit;
  logic          log_full;
  logic          do_push;
  logic          do_pop;

  // A store only counts while the run is still undecided.
  assign store_hit = MemWrite && (state == ST_RUN);
  assign log_full  = (log_count == DEPTH_CNT);
  assign log_valid = (log_count != {CW{1'b0}});
  assign do_pop    = log_valid && log_ready;
  // A full log still takes a store when the head leaves on the same edge.
  assign do_push   = store_hit && (!log_full || do_pop);

  // Head entry straight from storage; forced to zero while the log is empty.
  assign log_addr = log_valid ? addr_mem[rd_ptr] : 32'd0;
  assign log_data = log_valid ? data_mem[rd_ptr] : 32'd0;

  // Next-state decision: store outcome first, timeout only if no terminal store.
  always_comb begin
    next_state = state;
    next_code  = fail_code;
    count_inc  = cycle_count + 32'd1;
    case (state)
      ST_RUN: begin
        if (MemWrite) begin
          if (ALUResult == PASS_ADDR) begin
            if (WriteData == PASS_DATA) begin
              next_state = ST_PASS;
              next_code  = CODE_NONE;
            end else begin
              next_state = ST_FAIL;
              next_code  = CODE_DATA;
            end
          end else if (ALUResult == SCRATCH_ADDR) begin
            if (count_inc == TIMEOUT_CYCLES) begin
              next_state = ST_FAIL;
              next_code  = CODE_TIMEOUT;
            end else begin
              next_state = ST_RUN;
            end
          end else begin
            next_state = ST_FAIL;
            next_code  = CODE_ILLEGAL;
          end
        end else if (count_inc == TIMEOUT_CYCLES) begin
          next_state = ST_FAIL;
          next_code  = CODE_TIMEOUT;
        end else begin
          next_state = ST_RUN;
        end
      end
      ST_PASS: next_state = ST_PASS;
      ST_FAIL: next_state = ST_FAIL;
      default: begin
        next_state = ST_FAIL;
        next_code  = CODE_ILLEGAL;
      end
    endcase
  end

  // State register plus registered outcome outputs and the run cycle counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_RUN;
      done        <= 1'b0;
      pass        <= 1'b0;
      fail_code   <= CODE_NONE;
      cycle_count <= 32'd0;
    end else begin
      state     <= next_state;
      done      <= (next_state != ST_RUN);
      pass      <= (next_state == ST_PASS);
      fail_code <= next_code;
      if (state == ST_RUN) begin
        cycle_count <= count_inc;
      end
    end
  end

  // Log pointers, occupancy and the sticky overflow flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr       <= {PW{1'b0}};
      rd_ptr       <= {PW{1'b0}};
      log_count    <= {CW{1'b0}};
      log_overflow <= 1'b0;
    end else begin
      if (do_push) begin
        wr_ptr <= wr_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + {{(PW-1){1'b0}}, 1'b1};
      end
      case ({do_push, do_pop})
        2'b10:   log_count <= log_count + {{(CW-1){1'b0}}, 1'b1};
        2'b01:   log_count <= log_count - {{(CW-1){1'b0}}, 1'b1};
        default: log_count <= log_count;
      endcase
      if (store_hit && !do_push) begin
        log_overflow <= 1'b1;
      end
    end
  end

  // Log storage; contents are only meaningful behind a non-zero occupancy.
  always_ff @(posedge clk) begin
    if (do_push) begin
      addr_mem[wr_ptr] <= ALUResult;
      data_mem[wr_ptr] <= WriteData;
    end
  end

endmodule

// File: tb/tb_store_result_monitor.sv
// Self-checking bench for store_result_monitor: a table of per-edge vectors
// for the basic pass run, then hand-written sequences for the other outcomes,
// the log overflow cases and the asynchronous reset.

module tb_store_result_monitor;

  logic        clk;
  logic        reset;
  logic        MemWrite;
  logic [31:0] ALUResult;
  logic [31:0] WriteData;
  logic        done;
  logic        pass;
  logic [1:0]  fail_code;
  logic [31:0] cycle_count;
  logic        log_valid;
  logic        log_ready;
  logic [31:0] log_addr;
  logic [31:0] log_data;
  logic        log_overflow;

  int checks = 0;
  int errors = 0;

  store_result_monitor #(
    .PASS_ADDR      (32'd100),
    .PASS_DATA      (32'd25),
    .SCRATCH_ADDR   (32'd96),
    .TIMEOUT_CYCLES (32'd20),
    .LOG_DEPTH      (4)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .MemWrite     (MemWrite),
    .ALUResult    (ALUResult),
    .WriteData    (WriteData),
    .done         (done),
    .pass         (pass),
    .fail_code    (fail_code),
    .cycle_count  (cycle_count),
    .log_valid    (log_valid),
    .log_ready    (log_ready),
    .log_addr     (log_addr),
    .log_data     (log_data),
    .log_overflow (log_overflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        mw;
    logic [31:0] addr;
    logic [31:0] data;
    logic        rdy;
    logic        e_done;
    logic        e_pass;
    logic [1:0]  e_code;
    logic [31:0] e_count;
    logic        e_valid;
    logic [31:0] e_laddr;
    logic [31:0] e_ldata;
  } vec_t;

  vec_t tbl [8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic do_reset();
    reset     = 1'b1;
    MemWrite  = 1'b0;
    ALUResult = 32'd0;
    WriteData = 32'd0;
    log_ready = 1'b0;
    @(posedge clk);
    @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  // One clock edge with the given store strobe/payload and pop request.
  task automatic step(input logic mw, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    MemWrite  = mw;
    ALUResult = a;
    WriteData = d;
    log_ready = rdy;
    @(posedge clk);
    #1;
    MemWrite  = 1'b0;
    log_ready = 1'b0;
  endtask

  task automatic chk_outcome(input string tag, input logic d, input logic p,
                             input logic [1:0] c, input logic [31:0] n);
    chk({tag, "_done"},  {31'd0, done}, {31'd0, d});
    chk({tag, "_pass"},  {31'd0, pass}, {31'd0, p});
    chk({tag, "_code"},  {30'd0, fail_code}, {30'd0, c});
    chk({tag, "_count"}, cycle_count, n);
  endtask

  initial begin
    // Scratch store at edge 3, signature at edge 5, then drain and a late store.
    //            mw    addr     data    rdy   done  pass  code   count  valid laddr    ldata
    tbl[0] = '{1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 1'b0, 2'b00, 32'd1, 1'b0, 32'd0,   32'd0};
    tbl[1] = '{1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 1'b0, 2'b00, 32'd2, 1'b0, 32'd0,   32'd0};
    tbl[2] = '{1'b1, 32'd96,  32'd7,  1'b0, 1'b0, 1'b0, 2'b00, 32'd3, 1'b1, 32'd96,  32'd7};
    tbl[3] = '{1'b0, 32'd0,   32'd0,  1'b0, 1'b0, 1'b0, 2'b00, 32'd4, 1'b1, 32'd96,  32'd7};
    tbl[4] = '{1'b1, 32'd100, 32'd25, 1'b0, 1'b1, 1'b1, 2'b00, 32'd5, 1'b1, 32'd96,  32'd7};
    tbl[5] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b1, 2'b00, 32'd5, 1'b1, 32'd100, 32'd25};
    tbl[6] = '{1'b0, 32'd0,   32'd0,  1'b1, 1'b1, 1'b1, 2'b00, 32'd5, 1'b0, 32'd0,   32'd0};
    tbl[7] = '{1'b1, 32'd100, 32'd25, 1'b0, 1'b1, 1'b1, 2'b00, 32'd5, 1'b0, 32'd0,   32'd0};

    do_reset();
    chk_outcome("reset", 1'b0, 1'b0, 2'b00, 32'd0);
    chk("reset_valid", {31'd0, log_valid}, 32'd0);
    chk("reset_ovf", {31'd0, log_overflow}, 32'd0);

    for (int i = 0; i < 8; i++) begin
      step(tbl[i].mw, tbl[i].addr, tbl[i].data, tbl[i].rdy);
      chk_outcome($sformatf("vec%0d", i), tbl[i].e_done, tbl[i].e_pass, tbl[i].e_code, tbl[i].e_count);
      chk($sformatf("vec%0d_valid", i), {31'd0, log_valid}, {31'd0, tbl[i].e_valid});
      if (tbl[i].e_valid) begin
        chk($sformatf("vec%0d_laddr", i), log_addr, tbl[i].e_laddr);
        chk($sformatf("vec%0d_ldata", i), log_data, tbl[i].e_ldata);
      end
    end

    // Wrong data at the pass address; a later correct store is ignored.
    do_reset();
    for (int i = 0; i < 3; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd100, 32'd24, 1'b0);
    chk_outcome("wrongdata", 1'b1, 1'b0, 2'b10, 32'd4);
    step(1'b1, 32'd100, 32'd25, 1'b0);
    chk_outcome("wrongdata_late", 1'b1, 1'b0, 2'b10, 32'd4);
    chk("wrongdata_valid", {31'd0, log_valid}, 32'd1);
    chk("wrongdata_ldata", log_data, 32'd24);
    step(1'b0, 32'd0, 32'd0, 1'b1);
    chk("wrongdata_one_entry", {31'd0, log_valid}, 32'd0);

    // Illegal address at edge 2; count frozen afterwards.
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd200, 32'd25, 1'b0);
    chk_outcome("illegal", 1'b1, 1'b0, 2'b01, 32'd2);
    for (int i = 0; i < 50; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    chk_outcome("illegal_frozen", 1'b1, 1'b0, 2'b01, 32'd2);

    // Timeout with no stores.
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    chk_outcome("pre_timeout", 1'b0, 1'b0, 2'b00, 32'd19);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    chk_outcome("timeout", 1'b1, 1'b0, 2'b11, 32'd20);

    // Signature store on the timeout edge wins.
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd100, 32'd25, 1'b0);
    chk_outcome("tie_pass", 1'b1, 1'b1, 2'b00, 32'd20);

    // Scratch store on the timeout edge does not decide, so timeout applies.
    do_reset();
    for (int i = 0; i < 19; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd96, 32'd3, 1'b0);
    chk_outcome("tie_scratch", 1'b1, 1'b0, 2'b11, 32'd20);

    // Overflow: six stores into a four-entry log with no pops.
    do_reset();
    for (int k = 1; k <= 4; k++) step(1'b1, 32'd96, 32'(k), 1'b0);
    chk("ovf_before", {31'd0, log_overflow}, 32'd0);
    step(1'b1, 32'd96, 32'd5, 1'b0);
    step(1'b1, 32'd96, 32'd6, 1'b0);
    chk("ovf_set", {31'd0, log_overflow}, 32'd1);
    chk("ovf_head", log_data, 32'd1);
    for (int k = 2; k <= 4; k++) begin
      step(1'b0, 32'd0, 32'd0, 1'b1);
      chk($sformatf("ovf_drain%0d_valid", k), {31'd0, log_valid}, 32'd1);
      chk($sformatf("ovf_drain%0d", k), log_data, 32'(k));
    end
    step(1'b0, 32'd0, 32'd0, 1'b1);
    chk("ovf_empty", {31'd0, log_valid}, 32'd0);
    chk("ovf_sticky", {31'd0, log_overflow}, 32'd1);

    // Full log with push and pop on the same edge stays full.
    do_reset();
    for (int k = 11; k <= 14; k++) step(1'b1, 32'd96, 32'(k), 1'b0);
    step(1'b1, 32'd96, 32'd15, 1'b1);
    chk("fpp_no_ovf", {31'd0, log_overflow}, 32'd0);
    chk("fpp_head", log_data, 32'd12);
    step(1'b1, 32'd96, 32'd16, 1'b0);
    chk("fpp_still_full", {31'd0, log_overflow}, 32'd1);
    for (int k = 12; k <= 15; k++) begin
      chk($sformatf("fpp_drain%0d", k), log_data, 32'(k));
      step(1'b0, 32'd0, 32'd0, 1'b1);
    end
    chk("fpp_empty", {31'd0, log_valid}, 32'd0);

    // Asynchronous reset between edges at count 7.
    do_reset();
    step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b0, 32'd0, 32'd0, 1'b0);
    step(1'b1, 32'd96, 32'd9, 1'b0);
    for (int i = 0; i < 4; i++) step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("arst_pre_count", cycle_count, 32'd7);
    chk("arst_pre_valid", {31'd0, log_valid}, 32'd1);
    #2;
    reset = 1'b1;
    #1;
    chk_outcome("arst", 1'b0, 1'b0, 2'b00, 32'd0);
    chk("arst_valid", {31'd0, log_valid}, 32'd0);
    chk("arst_ovf", {31'd0, log_overflow}, 32'd0);
    chk("arst_laddr", log_addr, 32'd0);
    chk("arst_ldata", log_data, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    step(1'b0, 32'd0, 32'd0, 1'b0);
    chk("arst_restart_count", cycle_count, 32'd1);
    chk("arst_restart_valid", {31'd0, log_valid}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
